acia_rx: RTL and testbench

Serial receive submodule, the companion to the ACIA transmit path: 8N1, LSB first, idle high.
- Synchronises the asynchronous rx_serial line, detects a start bit and samples each bit at its midpoint.
- Presents the byte with a ready/acknowledge handshake, a framing-error flag and an overrun flag.
- Sits inside the ACIA wrapper; the CPU bus side polls rx_rdy and pulses rx_ack on a data read.

---
 rtl/acia_rx_pkg.sv | 10 +
 rtl/acia_sync.sv | 13 +
 rtl/acia_rx.sv | 88 ++++++++
 tb/tb_acia_rx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/acia_rx_pkg.sv
// acia_rx_pkg: state encoding and default rate constants shared by the ACIA receive and transmit paths.
package acia_rx_pkg;
    localparam int SCW_DEF = 8;
    localparam int SYM_CNT_DEF = 139;
    typedef logic [1:0] state_t;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] STOP = 2'd3;
endpackage

// File: rtl/acia_sync.sv
// acia_sync: two-flop synchroniser for an idle-high asynchronous line.
module acia_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk) begin
        if (!rst) {q, m} <= 2'b11;
        else {q, m} <= {m, d};
    end
endmodule

// File: rtl/acia_rx.sv
// acia_rx: 8N1 serial receiver with mid-bit sampling, ready/ack handshake, framing and overrun flags.
module acia_rx
    import acia_rx_pkg::*;
#(
    parameter int SCW = SCW_DEF,
    parameter int sym_cnt = SYM_CNT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    input  logic       rx_ack,
    output logic [7:0] rx_dat,
    output logic       rx_rdy,
    output logic       rx_stb,
    output logic       rx_ferr,
    output logic       rx_ovr,
    output logic       rx_busy
);
    localparam logic [SCW-1:0] SYM = SCW'(sym_cnt);
    localparam logic [SCW-1:0] HALF = SCW'(sym_cnt >> 1);
    logic rx_s;
    state_t state;
    logic [SCW-1:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] sr;
    logic armed;
    logic tick;
    acia_sync u_sync (.clk(clk), .rst(rst), .d(rx_serial), .q(rx_s));
    assign tick = (cnt == '0) && (state != IDLE);
    assign rx_busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            bit_cnt <= '0;
            sr <= '0;
            armed <= 1'b0;
            rx_dat <= '0;
            rx_ferr <= 1'b0;
            rx_stb <= 1'b0;
        end else begin
            rx_stb <= 1'b0;
            cnt <= (cnt != '0) ? cnt - SCW'(1) : cnt;
            case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        state <= START;
                        cnt <= HALF;
                        armed <= 1'b0;
                    end else if (rx_s) armed <= 1'b1;
                end
                START: begin
                    if (tick) begin
                        state <= rx_s ? IDLE : DATA;
                        cnt <= SYM;
                        bit_cnt <= 3'd7;
                    end
                end
                DATA: begin
                    if (tick) begin
                        sr <= {rx_s, sr[7:1]};
                        cnt <= SYM;
                        state <= (bit_cnt == 3'd0) ? STOP : DATA;
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                end
                default: begin
                    // Leaving at mid-stop gives half a bit to catch a back-to-back start edge.
                    if (tick) begin
                        rx_dat <= sr;
                        rx_ferr <= ~rx_s;
                        rx_stb <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_rdy <= 1'b0;
            rx_ovr <= 1'b0;
        end else begin
            rx_rdy <= rx_stb ? 1'b1 : (rx_ack ? 1'b0 : rx_rdy);
            rx_ovr <= (rx_stb && rx_rdy && !rx_ack) ? 1'b1 : (rx_ack ? 1'b0 : rx_ovr);
        end
    end
endmodule

// File: tb/tb_acia_rx.sv
// tb_acia_rx: frame-level reference model of the receiver driven with directed and random serial traffic.
module tb_acia_rx;
    localparam int BIT = 140;
    localparam int LAT = 1333;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_serial = 1'b1;
    logic rx_ack = 1'b0;
    logic [7:0] rx_dat;
    logic rx_rdy, rx_stb, rx_ferr, rx_ovr, rx_busy;
    int cyc = 0;
    int stb_cnt = 0;
    int stb_cyc = 0;
    int checks = 0;
    int errors = 0;
    logic rdy_m = 1'b0;
    logic ovr_m = 1'b0;

    acia_rx dut (
        .clk(clk), .rst(rst), .rx_serial(rx_serial), .rx_ack(rx_ack),
        .rx_dat(rx_dat), .rx_rdy(rx_rdy), .rx_stb(rx_stb),
        .rx_ferr(rx_ferr), .rx_ovr(rx_ovr), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rx_stb) begin
            stb_cnt <= stb_cnt + 1;
            stb_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk) rx_ack = 1'b1;
        @(negedge clk) rx_ack = 1'b0;
        if (rdy_m) begin
            rdy_m = 1'b0;
            ovr_m = 1'b0;
        end
        chk("ack_rdy", rx_rdy, rdy_m);
        chk("ack_ovr", rx_ovr, ovr_m);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input bit ack_on_stb);
        logic [9:0] fr;
        int c0, n0;
        bit acked;
        fr = {stop, b, 1'b0};
        n0 = stb_cnt;
        c0 = cyc;
        acked = 0;
        for (int i = 0; i < 10; i++) begin
            rx_serial = fr[i];
            repeat (BIT) begin
                @(negedge clk);
                if (ack_on_stb && rx_stb && !acked) begin
                    rx_ack = 1'b1;
                    acked = 1;
                end else rx_ack = 1'b0;
            end
        end
        rx_ack = 1'b0;
        chk("stb_n", stb_cnt - n0, 1);
        chk("lat", stb_cyc - c0, LAT);
        chk("dat", rx_dat, b);
        chk("ferr", rx_ferr, !stop);
        if (ack_on_stb) chk("ack_hit", acked, 1);
        ovr_m = (rdy_m && !acked) ? 1'b1 : (acked ? 1'b0 : ovr_m);
        rdy_m = 1'b1;
        chk("rdy", rx_rdy, rdy_m);
        chk("ovr", rx_ovr, ovr_m);
        chk("busy_end", rx_busy, 0);
    endtask

    initial begin
        int n0;
        logic [7:0] d0;
        logic [7:0] b;
        logic st;
        logic [9:0] fr;
        repeat (3) @(negedge clk);
        chk("rst_dat", rx_dat, 0);
        chk("rst_rdy", rx_rdy, 0);
        chk("rst_stb", rx_stb, 0);
        chk("rst_ferr", rx_ferr, 0);
        chk("rst_ovr", rx_ovr, 0);
        chk("rst_busy", rx_busy, 0);
        rst = 1'b1;
        idle(20);

        send(8'hA5, 1'b1, 0);
        idle(50);

        n0 = stb_cnt;
        d0 = rx_dat;
        rx_serial = 1'b0;
        repeat (40) @(negedge clk);
        chk("glitch_busy", rx_busy, 1);
        idle(200);
        chk("glitch_idle", rx_busy, 0);
        chk("glitch_stb", stb_cnt - n0, 0);
        chk("glitch_dat", rx_dat, d0);

        ack();
        send(8'h3C, 1'b0, 0);
        n0 = stb_cnt;
        repeat (3000) @(negedge clk);
        chk("brk_stb", stb_cnt - n0, 0);
        chk("brk_busy", rx_busy, 0);
        idle(50);
        ack();
        send(8'h55, 1'b1, 0);
        idle(10);

        ack();
        send(8'h11, 1'b1, 0);
        send(8'h22, 1'b1, 0);
        chk("ovr_set", rx_ovr, 1);
        ack();

        send(8'h11, 1'b1, 0);
        send(8'h22, 1'b1, 1);
        chk("same_rdy", rx_rdy, 1);
        chk("same_ovr", rx_ovr, 0);
        idle(10);

        send(8'h5A, 1'b1, 0);
        fr = {1'b1, 8'hF0, 1'b0};
        n0 = stb_cnt;
        for (int i = 0; i < 500; i++) begin
            rx_serial = fr[i / BIT];
            @(negedge clk);
        end
        rst = 1'b0;
        rx_serial = 1'b1;
        @(negedge clk) rst = 1'b1;
        rdy_m = 1'b0;
        ovr_m = 1'b0;
        chk("mr_dat", rx_dat, 0);
        chk("mr_rdy", rx_rdy, 0);
        chk("mr_stb", rx_stb, 0);
        chk("mr_ferr", rx_ferr, 0);
        chk("mr_ovr", rx_ovr, 0);
        chk("mr_busy", rx_busy, 0);
        idle(1500);
        chk("mr_nostb", stb_cnt - n0, 0);
        send(8'h81, 1'b1, 0);

        repeat (14) begin
            b = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            send(b, st, 0);
            if (!st) idle(5 + $urandom_range(0, 20));
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 30));
            if ($urandom_range(0, 1) == 1) ack();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
